aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  Sequential AES-128 key schedule feeding the cipher core's round-key input.
//  Accepts a 128-bit cipher key on a start pulse and generates round keys 0..10
//  at one per clock, per FIPS-197. Each key is streamed out as it is produced
//  and also held in an 11-entry store that the cipher reads by round index.
// PARAMETERS
//  NUM_ROUNDS  10  AES-128 round count. Only the value 10 is supported.
// PORTS
//  clk            in   1    system clock, rising edge
//  rst_n          in   1    asynchronous active-low reset
//  start          in   1    begin expansion of key_in. Sampled only when not busy.
//  key_in         in   128  cipher key; key_in[127:96] is w0
//  busy           out  1    expansion in progress
//  done           out  1    all 11 round keys valid in store (level)
//  rk_strm_valid  out  1    rk_strm/rk_strm_round carry a freshly generated key
//  rk_strm_round  out  4    round index of rk_strm (0..10)
//  rk_strm        out  128  streamed round key
//  rk_idx         in   4    store read address
//  rk_out         out  128  registered store read data
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all outputs 0; all 11 store entries 0; round counter 0.
//   - Reset mid-expansion aborts it. No partial done is produced.
//  FSM states: IDLE, EXPAND, DONE.
//   - IDLE/DONE -> EXPAND on edge E0 with start=1.
//   - EXPAND -> DONE after round 10 is written.
//  Edge E0 (start accepted):
//   - store[0]=key_in; cur=key_in; rcnt=1; busy=1; done=0.
//   - rk_strm_valid=1, rk_strm_round=0, rk_strm=key_in.
//  Edges E1..E10, with k=rcnt:
//   - t = SubWord(RotWord(cur.w3)) ^ {RCON[k],24'h0}
//   - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2
//   - store[k]={n0,n1,n2,n3}; cur updated; rcnt++
//   - rk_strm_valid=1, rk_strm_round=k, rk_strm={n0..n3}
//  After E10: state=DONE, busy=0, done=1.
//   - rk_strm_valid falls after E11; it is high for exactly 11 cycles.
//  RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
//  SubWord: four instances of the existing AES S-box submodule, combinational.
//  Start handling:
//   - start while busy is ignored. key_in is not re-sampled and the run is unchanged.
//   - start in DONE restarts: done drops after E0 and the store is overwritten
//     entry by entry.
//  Store reads:
//   - Latency 1: rk_out after edge N = store[rk_idx sampled at N].
//   - rk_idx 11..15 returns 128'h0.
//   - A read of the entry being written on the same edge returns the old value.
//  key_in is only required stable at E0.
//  done remains high until the next accepted start or reset.
// TESTING
//  1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
//     - stream round1 = a0fafe1788542cb123a339392a6c7605
//     - stream round10 = d014f9a8c9ee2589e13f0cc8b6630ca6
//     - done rises 11 edges after start; busy is high for 10 cycles.
//  2. After test 1, read rk_idx 0..15:
//     - idx0 = key; idx1 and idx10 match the test 1 values.
//     - idx2 = f2c295f27a96b9435935807a7359f67f
//     - idx11..15 = 0; each result appears one cycle after its index.
//  3. Pulse start with key 000..0 at E4 of a running expansion:
//     - ignored; the test 1 results are unchanged.
//  4. Assert rst_n=0 asynchronously at E5 of an expansion:
//     - outputs and store read 0 immediately; done never rises.
//     - A following start completes normally.
//  5. Restart from DONE with key 000102030405060708090a0b0c0d0e0f:
//     - round10 = 13111d7fe3944a17f307a78b4d2b30c5
//     - done low during the run, high after.
//  6. Hold start high continuously:
//     - exactly one expansion per IDLE/DONE entry.
//     - rk_strm_valid is high 11 of every 12 cycles.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per clock, streamed out and kept in an
// 11-entry store that the cipher core reads by round index with one cycle of latency.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = '0;
        m = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = xtime(m);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127, b;
        x3   = gmul(gmul(x, x), x);
        x7   = gmul(gmul(x3, x3), x);
        x15  = gmul(gmul(x7, x7), x);
        x31  = gmul(gmul(x15, x15), x);
        x63  = gmul(gmul(x31, x31), x);
        x127 = gmul(gmul(x63, x63), x);
        b    = gmul(x127, x127);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s = sbox(a);
endmodule

module aes_key_expand #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_strm_valid,
    output logic [3:0]   rk_strm_round,
    output logic [127:0] rk_strm,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    logic [127:0] store [0:NUM_ROUNDS];
    logic [127:0] cur;
    logic [3:0]   rcnt;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [7:0]   rcon;
    logic [31:0]  t, n0, n1, n2, n3;

    assign rot = {cur[23:0], cur[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (.a(rot[8*g +: 8]), .s(sub[8*g +: 8]));
    end

    always_comb begin
        rcon = 8'h00;
        case (rcnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = cur[127:96] ^ t;
    assign n1 = cur[95:64]  ^ n0;
    assign n2 = cur[63:32]  ^ n1;
    assign n3 = cur[31:0]   ^ n2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rk_strm_valid <= 1'b0;
            rk_strm_round <= '0;
            rk_strm       <= '0;
            rk_out        <= '0;
            cur           <= '0;
            rcnt          <= '0;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
        end else begin
            rk_out <= (rk_idx <= LAST) ? store[rk_idx] : '0;
            case (state)
                IDLE, DONE: begin
                    rk_strm_valid <= 1'b0;
                    // Starts are held off while the last key is still on the stream,
                    // which leaves a one-cycle gap between back-to-back expansions.
                    if (start && !rk_strm_valid) begin
                        state         <= EXPAND;
                        store[0]      <= key_in;
                        cur           <= key_in;
                        rcnt          <= 4'd1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        rk_strm_valid <= 1'b1;
                        rk_strm_round <= '0;
                        rk_strm       <= key_in;
                    end
                end
                EXPAND: begin
                    store[rcnt]   <= {n0, n1, n2, n3};
                    cur           <= {n0, n1, n2, n3};
                    rk_strm_valid <= 1'b1;
                    rk_strm_round <= rcnt;
                    rk_strm       <= {n0, n1, n2, n3};
                    if (rcnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key schedule vectors.

module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rk_idx = '0;
    logic         busy, done, rk_strm_valid;
    logic [3:0]   rk_strm_round;
    logic [127:0] rk_strm, rk_out;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [127:0] k1 [0:10];

    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .rk_strm_valid(rk_strm_valid),
        .rk_strm_round(rk_strm_round), .rk_strm(rk_strm),
        .rk_idx(rk_idx), .rk_out(rk_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        n_total++;
        if ({busy, done, rk_strm_valid, rk_strm_round, rk_strm, rk_out} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b round=%0d strm=%h out=%h, want all 0",
                     busy, done, rk_strm_valid, rk_strm_round, rk_strm, rk_out);
        else n_pass++;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fips_stream;
        int unsigned busy_cnt;
        key_in = k1[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        key_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        busy_cnt = busy;
        n_total++;
        if ({rk_strm_valid, rk_strm_round, rk_strm, busy, done} !== {1'b1, 4'd0, k1[0], 1'b1, 1'b0})
            $display("FAIL fips_e0: got valid=%b round=%0d strm=%h busy=%b done=%b, want 1 0 %h 1 0",
                     rk_strm_valid, rk_strm_round, rk_strm, busy, done, k1[0]);
        else n_pass++;
        for (int r = 1; r <= 10; r++) begin
            tick;
            busy_cnt += busy;
            n_total++;
            if ({rk_strm_valid, rk_strm_round, rk_strm} !== {1'b1, 4'(r), k1[r]})
                $display("FAIL fips_round%0d: got valid=%b round=%0d strm=%h, want 1 %0d %h",
                         r, rk_strm_valid, rk_strm_round, rk_strm, r, k1[r]);
            else n_pass++;
            n_total++;
            if (done !== (r == 10))
                $display("FAIL fips_done_e%0d: got %b, want %b", r, done, r == 10);
            else n_pass++;
        end
        tick;
        busy_cnt += busy;
        n_total++;
        if ({rk_strm_valid, busy, done} !== 3'b001)
            $display("FAIL fips_e11: got valid=%b busy=%b done=%b, want 0 0 1", rk_strm_valid, busy, done);
        else n_pass++;
        n_total++;
        if (busy_cnt != 10) $display("FAIL fips_busy_cycles: got %0d, want 10", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_store_read;
        logic [127:0] exp_v, prev;
        prev = rk_out;
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            #1;
            n_total++;
            if (rk_out !== prev) $display("FAIL read_latency_idx%0d: got %h, want %h", i, rk_out, prev);
            else n_pass++;
            tick;
            exp_v = (i <= 10) ? k1[i] : '0;
            n_total++;
            if (rk_out !== exp_v) $display("FAIL read_idx%0d: got %h, want %h", i, rk_out, exp_v);
            else n_pass++;
            prev = exp_v;
        end
    endtask

    task automatic test_start_ignored;
        key_in = k1[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            if (r == 4) begin
                start = 1'b1;
                key_in = '0;
            end
            tick;
            start = 1'b0;
            n_total++;
            if ({rk_strm_round, rk_strm} !== {4'(r), k1[r]})
                $display("FAIL ignore_round%0d: got round=%0d strm=%h, want %0d %h",
                         r, rk_strm_round, rk_strm, r, k1[r]);
            else n_pass++;
        end
        tick;
        n_total++;
        if ({busy, done, rk_strm_valid} !== 3'b010)
            $display("FAIL ignore_end: got busy=%b done=%b valid=%b, want 0 1 0", busy, done, rk_strm_valid);
        else n_pass++;
        rk_idx = 4'd5;
        tick;
        n_total++;
        if (rk_out !== k1[5]) $display("FAIL ignore_store5: got %h, want %h", rk_out, k1[5]);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        int unsigned done_seen;
        key_in = k1[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int r = 1; r <= 5; r++) tick;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, rk_strm_valid, rk_strm_round, rk_strm, rk_out} !== '0)
            $display("FAIL areset_outputs: got busy=%b done=%b valid=%b round=%0d strm=%h out=%h, want all 0",
                     busy, done, rk_strm_valid, rk_strm_round, rk_strm, rk_out);
        else n_pass++;
        done_seen = 0;
        rk_idx = 4'd1;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) rst_n = 1'b1;
            tick;
            done_seen += done;
        end
        n_total++;
        if (done_seen != 0) $display("FAIL areset_no_done: got %0d done cycles, want 0", done_seen);
        else n_pass++;
        n_total++;
        if (rk_out !== '0) $display("FAIL areset_store_cleared: got %h, want 0", rk_out);
        else n_pass++;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int r = 1; r <= 10; r++) tick;
        n_total++;
        if ({done, rk_strm_round, rk_strm} !== {1'b1, 4'd10, k1[10]})
            $display("FAIL areset_rerun: got done=%b round=%0d strm=%h, want 1 10 %h",
                     done, rk_strm_round, rk_strm, k1[10]);
        else n_pass++;
        tick;
    endtask

    task automatic test_restart;
        key_in = K2;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_total++;
        if ({done, rk_strm} !== {1'b0, K2})
            $display("FAIL restart_e0: got done=%b strm=%h, want 0 %h", done, rk_strm, K2);
        else n_pass++;
        for (int r = 1; r <= 10; r++) begin
            tick;
            if (r < 10) begin
                n_total++;
                if (done !== 1'b0) $display("FAIL restart_done_low_e%0d: got %b, want 0", r, done);
                else n_pass++;
            end
            if (r == 1) begin
                n_total++;
                if (rk_strm !== K2_R1) $display("FAIL restart_round1: got %h, want %h", rk_strm, K2_R1);
                else n_pass++;
            end
        end
        n_total++;
        if ({done, rk_strm_round, rk_strm} !== {1'b1, 4'd10, K2_R10})
            $display("FAIL restart_round10: got done=%b round=%0d strm=%h, want 1 10 %h",
                     done, rk_strm_round, rk_strm, K2_R10);
        else n_pass++;
        rk_idx = 4'd10;
        tick;
        n_total++;
        if (rk_out !== K2_R10) $display("FAIL restart_store10: got %h, want %h", rk_out, K2_R10);
        else n_pass++;
        tick;
    endtask

    task automatic test_back_to_back;
        int unsigned vcnt, r0cnt;
        vcnt = 0;
        r0cnt = 0;
        key_in = k1[0];
        start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick;
            vcnt += rk_strm_valid;
            if (rk_strm_valid && rk_strm_round == 4'd0) r0cnt++;
            if (rk_strm_valid && rk_strm_round == 4'd10) begin
                n_total++;
                if (rk_strm !== k1[10]) $display("FAIL held_round10_c%0d: got %h, want %h", c, rk_strm, k1[10]);
                else n_pass++;
            end
        end
        start = 1'b0;
        n_total++;
        if (vcnt != 22) $display("FAIL held_valid_cycles: got %0d, want 22", vcnt);
        else n_pass++;
        n_total++;
        if (r0cnt != 2) $display("FAIL held_expansions: got %0d, want 2", r0cnt);
        else n_pass++;
        tick;
        n_total++;
        if ({busy, done, rk_strm_valid} !== 3'b010)
            $display("FAIL held_end: got busy=%b done=%b valid=%b, want 0 1 0", busy, done, rk_strm_valid);
        else n_pass++;
    endtask

    initial begin
        k1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        k1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        k1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        k1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        k1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        k1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        k1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        k1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        k1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        k1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        test_reset;
        test_fips_stream;
        test_store_read;
        test_start_ignored;
        test_async_reset;
        test_restart;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
